// File: rtl/ora_session_ctrl.sv
// ora_session_ctrl: transition-count ORA session controller (optional fail capture via ORA_FAIL_CAPTURE_EN)
module ora_session_ctrl #(
  parameter int BITS = 32,
  parameter int PAT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PAT_BITS-1:0] num_patterns,
  input  logic [BITS-1:0]     golden,
  input  logic                resp,
  input  logic [BITS-1:0]     count,
  output logic                cnt_rst,
  output logic                inc,
  output logic [PAT_BITS-1:0] pat_idx,
  output logic                busy,
  output logic                done,
  output logic                pass
`ifdef ORA_FAIL_CAPTURE_EN
  ,
  output logic [BITS-1:0]     fail_sig
`endif
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE} state_t;
  state_t state;
  logic [PAT_BITS-1:0] n_q;
  logic [BITS-1:0] gold_q;
  logic prev_resp;
  // session sequencer; all outputs registered so each reflects the state it is entering
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_q <= '0;
      gold_q <= '0;
      cnt_rst <= 1'b0;
      inc <= 1'b0;
      pat_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      prev_resp <= 1'b0;
`ifdef ORA_FAIL_CAPTURE_EN
      fail_sig <= '0;
`endif
    end else begin
      cnt_rst <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state <= CLEAR;
          n_q <= num_patterns;
          gold_q <= golden;
          cnt_rst <= 1'b1;
          inc <= 1'b0;
          pat_idx <= '0;
          prev_resp <= 1'b0;
          busy <= 1'b1;
          done <= 1'b0;
          pass <= 1'b0;
`ifdef ORA_FAIL_CAPTURE_EN
          fail_sig <= '0;
`endif
        end
        CLEAR: state <= (n_q != '0) ? RUN : SETTLE;
        RUN: begin
          inc <= resp ^ prev_resp;
          prev_resp <= resp;
          pat_idx <= pat_idx + 1'b1;
          if (pat_idx == n_q - 1'b1) state <= SETTLE;
        end
        SETTLE: begin
          inc <= 1'b0;
          state <= COMPARE;
        end
        COMPARE: begin
          pass <= (count == gold_q);
          done <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
`ifdef ORA_FAIL_CAPTURE_EN
          fail_sig <= (count != gold_q) ? count : '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
